// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding APB4 initiator driven by a valid/ready request/response channel.
// Handles wait states, slave errors, misaligned requests and hung-slave timeout.
module apb_master_bridge #(
  parameter int TIMEOUT = 16
) (
  input  logic        pclk_i,
  input  logic        presetn_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic        req_write_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_strb_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        rsp_timeout_o,
  output logic [31:0] paddr_o,
  output logic        psel_o,
  output logic        penable_o,
  output logic        pwrite_o,
  output logic [31:0] pwdata_o,
  output logic [3:0]  pstrb_o,
  input  logic        pready_i,
  input  logic [31:0] prdata_i,
  input  logic        pslverr_i
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  localparam int CW = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          w_misaligned;
  logic          w_expire;
  assign req_ready_o  = (r_state == IDLE);
  assign w_misaligned = |req_addr_i[1:0];
  // expiry fires on the TIMEOUT-th consecutive ACCESS cycle without pready
  assign w_expire     = (TIMEOUT != 0) && (r_cnt == TLAST);
  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      rsp_valid_o   <= 1'b0;
      rsp_rdata_o   <= '0;
      rsp_err_o     <= 1'b0;
      rsp_timeout_o <= 1'b0;
      paddr_o       <= '0;
      psel_o        <= 1'b0;
      penable_o     <= 1'b0;
      pwrite_o      <= 1'b0;
      pwdata_o      <= '0;
      pstrb_o       <= '0;
    end else begin
      case (r_state)
        IDLE: if (req_valid_i) begin
          paddr_o  <= req_addr_i;
          pwrite_o <= req_write_i;
          pwdata_o <= req_wdata_i;
          pstrb_o  <= req_write_i ? req_strb_i : 4'h0;
          if (w_misaligned) begin
            rsp_valid_o   <= 1'b1;
            rsp_err_o     <= 1'b1;
            rsp_timeout_o <= 1'b0;
            rsp_rdata_o   <= '0;
            r_state       <= RESP;
          end else begin
            psel_o  <= 1'b1;
            r_cnt   <= '0;
            r_state <= SETUP;
          end
        end
        SETUP: begin
          penable_o <= 1'b1;
          r_state   <= ACCESS;
        end
        ACCESS: if (pready_i || w_expire) begin
          psel_o        <= 1'b0;
          penable_o     <= 1'b0;
          rsp_valid_o   <= 1'b1;
          rsp_err_o     <= pready_i ? pslverr_i : 1'b1;
          rsp_timeout_o <= !pready_i;
          rsp_rdata_o   <= (pready_i && !pwrite_o && !pslverr_i) ? prdata_i : 32'h0;
          r_state       <= RESP;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        RESP: if (rsp_ready_i) begin
          rsp_valid_o <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
